pe_output_deskew: RTL and testbench
===================================

Name: pe_output_deskew

Overview:
- Sits directly downstream of the PE array and consumes its raw, skewed bottom-edge output.
- Column j of the array output lags column 0 by j cycles; this block re-aligns every column so one complete result row appears per beat.
- Aligned rows are buffered in a small FIFO and presented on a ready/valid stream, with a row index and a tile-last flag.
- Absorbs short downstream stalls; the array itself cannot be back-pressured.

Parameters:
DATA_WIDTH, 8, operand width; each result lane is 2*DATA_WIDTH bits
COLS, 8, number of array columns / result lanes
ROWS, 8, rows per output tile; sets row-index wrap and the last flag
FIFO_DEPTH, 16, aligned-row FIFO entries; power of two, >=2

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of all state
in_valid  input  1  column 0 of C_in carries a valid row this cycle
C_in  input  COLS*2*DATA_WIDTH  skewed array output; lane j at bits [(j+1)*2*DATA_WIDTH-1 -: 2*DATA_WIDTH]
m_valid  output  1  FIFO head valid
m_ready  input  1  downstream accepts head
m_data  output  COLS*2*DATA_WIDTH  aligned row, same lane packing as C_in
m_row_idx  output  $clog2(ROWS) (min 1)  row index within tile
m_last  output  1  m_row_idx == ROWS-1
overflow  output  1  sticky: an aligned row was dropped
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 (m_valid=0, m_data=0, m_row_idx=0, m_last=0, overflow=0, fifo_count=0); all delay lines, valid pipeline, counter and FIFO pointers cleared.
- Deskew: lane j passes through a register delay line of COLS-1-j stages. Lane COLS-1 has no delay.
- Valid alignment: in_valid passes through a COLS-1 stage shift register to give aligned_valid. When in_valid is high at cycle T, the full row is aligned combinationally during cycle T+COLS-1.
- Write: on the edge ending cycle T+COLS-1, if aligned_valid is high and the FIFO is not full, the aligned row and the current row counter are pushed. m_valid can rise at T+COLS at the earliest (latency COLS from in_valid).
- Row counter: advances by 1 on every aligned_valid beat and wraps ROWS-1 -> 0. It advances even when the row is dropped, so tile framing is preserved.
- Overflow: aligned_valid while the FIFO is full and no pop occurs drops the row and sets overflow. overflow stays set until clear or reset.
- Pop: occurs when m_valid && m_ready. m_data, m_row_idx and m_last reflect the FIFO head and hold stable while m_valid && !m_ready.
- Full and pop in the same cycle: the push is accepted, fifo_count is unchanged and no overflow is raised.
- Empty FIFO: m_valid=0 and m_ready is ignored. An incoming push is not visible until the next cycle (no fall-through).
- Pointers: wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
- Back-to-back input: in_valid may be high every cycle; sustained throughput is one row per cycle while m_ready=1.
- clear: synchronous and dominant over push and pop in the same cycle. It zeroes the valid pipeline, FIFO pointers/count, row counter and overflow. In-flight skewed data is discarded; delay-line data registers need not be zeroed.
- Mid-operation reset: asynchronous return to the reset state; partially received rows are lost.
- Arithmetic: lanes are passed bit-exact and treated as signed 2*DATA_WIDTH values; no truncation or extension.

Optional Feature:
- Macro DESKEW_RELU_EN.
- When defined: each lane is clamped at FIFO write; a negative (MSB=1) lane is written as 0 and other lanes pass unchanged. Latency is unchanged.
- When undefined: lanes pass bit-exact and no clamp logic is built.

Test Plan:
- Skew alignment: COLS=8; drive lane j = 16'h0100+j only at cycle T+j, with in_valid at T -> exactly one m_valid beat at T+8, m_data lanes 0x0100..0x0107, m_row_idx=0.
- Tile framing: 8 consecutive in_valid rows with m_ready=1 -> 8 beats, m_row_idx 0..7, m_last only on the 8th; a 9th row gets m_row_idx=0.
- Backpressure/overflow: FIFO_DEPTH=16, m_ready=0, 17 rows in -> fifo_count=16 and overflow=1 after the 17th aligns. Then m_ready=1 -> rows 0..15 out in order, and the 17th row's index was consumed by the counter.
- Full with simultaneous pop: FIFO full, m_ready=1 on the same cycle as aligned_valid -> fifo_count stays 16, overflow stays 0, no row lost.
- Clear and reset: clear with 3 rows in the delay pipeline and 5 in the FIFO -> next cycle fifo_count=0, m_valid=0, and no stray beats follow. rst_n low mid-stream -> all outputs 0 immediately.
- With DESKEW_RELU_EN: lane value 16'hFFF0 -> output lane 0x0000; 16'h007F -> 0x007F.

Source files
------------

// File: rtl/pe_output_deskew.sv
// Re-aligns the skewed bottom-edge output of the PE array into whole rows and buffers them on a ready/valid stream.
// Optional build macro DESKEW_RELU_EN clamps negative lanes to zero at FIFO write.
module pe_output_deskew #(
    parameter int DATA_WIDTH = 8,
    parameter int COLS       = 8,
    parameter int ROWS       = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int LW = 2 * DATA_WIDTH,
    localparam int DW = COLS * LW,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] C_in,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [RW-1:0] m_row_idx,
    output logic          m_last,
    output logic          overflow,
    output logic [CW-1:0] fifo_count
);

    logic [DW-1:0] aligned_row;
    logic [DW-1:0] wr_row;
    logic          aligned_valid;

    // Lane gi lags lane 0 by gi cycles, so it needs COLS-1-gi stages to line up with the last lane.
    for (genvar gi = 0; gi < COLS; gi++) begin : g_lane
        localparam int STAGES = COLS - 1 - gi;
        if (STAGES == 0) begin : g_pass
            assign aligned_row[gi*LW +: LW] = C_in[gi*LW +: LW];
        end else begin : g_dly
            logic [LW-1:0] dly_q [STAGES];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < STAGES; k++) dly_q[k] <= '0;
                end else begin
                    dly_q[0] <= C_in[gi*LW +: LW];
                    for (int k = 1; k < STAGES; k++) dly_q[k] <= dly_q[k-1];
                end
            end
            assign aligned_row[gi*LW +: LW] = dly_q[STAGES-1];
        end

`ifdef DESKEW_RELU_EN
        assign wr_row[gi*LW +: LW] = aligned_row[gi*LW + LW - 1] ? '0 : aligned_row[gi*LW +: LW];
`else
        assign wr_row[gi*LW +: LW] = aligned_row[gi*LW +: LW];
`endif
    end

    if (COLS > 1) begin : g_vpipe
        logic [COLS-2:0] vpipe_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)     vpipe_q <= '0;
            else if (clear) vpipe_q <= '0;
            else            vpipe_q <= (vpipe_q << 1) | (COLS-1)'(in_valid);
        end
        assign aligned_valid = vpipe_q[COLS-2];
    end else begin : g_novpipe
        assign aligned_valid = in_valid;
    end

    logic [RW+DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [RW-1:0]    row_cnt_q;
    logic             overflow_q;
    logic             full, empty, push, pop;
    logic [RW+DW-1:0] head;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && m_ready;
    // A full FIFO still takes the row when the head leaves in the same cycle.
    assign push  = aligned_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= {row_cnt_q, wr_row};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Dropped rows still consume an index so tile framing survives an overflow.
            if (aligned_valid)
                row_cnt_q <= (row_cnt_q == RW'(ROWS - 1)) ? '0 : row_cnt_q + 1'b1;
            if (aligned_valid && full && !pop)
                overflow_q <= 1'b1;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign m_valid    = !empty;
    assign m_data     = m_valid ? head[DW-1:0] : '0;
    assign m_row_idx  = m_valid ? head[RW+DW-1:DW] : '0;
    assign m_last     = m_valid && (head[RW+DW-1:DW] == RW'(ROWS - 1));
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_pe_output_deskew.sv
// Randomized and directed bench for pe_output_deskew; expected rows come from a queue-based row/FIFO model.
module tb_pe_output_deskew;
    localparam int COLS  = 8;
    localparam int LW    = 16;
    localparam int W     = COLS * LW;
    localparam int ROWS  = 8;
    localparam int DEPTH = 16;

    logic          clk, rst_n, clear, in_valid, m_ready;
    logic [W-1:0]  C_in, m_data;
    logic          m_valid, m_last, overflow;
    logic [2:0]    m_row_idx;
    logic [4:0]    fifo_count;

    pe_output_deskew #(.DATA_WIDTH(8), .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .C_in(C_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row_idx(m_row_idx),
        .m_last(m_last), .overflow(overflow), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic [2:0]   idx;
    } ent_t;

    ent_t         mq[$];
    logic [W-1:0] ring_d [16];
    bit           ring_v [16];
    int           cyc;
    int           rowcnt;
    bit           ovf;
    int           n_checks;
    int           n_errors;

    function automatic logic [W-1:0] relu(input logic [W-1:0] r);
        logic [W-1:0] o;
        o = r;
`ifdef DESKEW_RELU_EN
        for (int j = 0; j < COLS; j++)
            if (o[j*LW + LW - 1]) o[j*LW +: LW] = '0;
`endif
        return o;
    endfunction

    function automatic logic [W-1:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_flush();
        mq.delete();
        ovf    = 1'b0;
        rowcnt = 0;
        for (int k = 0; k < 16; k++) ring_v[k] = 1'b0;
    endtask

    task automatic check_outputs();
        chk("m_valid", W'(m_valid), W'(mq.size() != 0));
        chk("fifo_count", W'(fifo_count), W'(mq.size()));
        chk("overflow", W'(overflow), W'(ovf));
        if (mq.size() != 0) begin
            chk("m_data", m_data, mq[0].d);
            chk("m_row_idx", W'(m_row_idx), W'(mq[0].idx));
            chk("m_last", W'(m_last), W'(mq[0].idx == 3'(ROWS - 1)));
        end
    endtask

    // One clock cycle: row issued now enters lane j of C_in j cycles later.
    task automatic tick(input bit v, input logic [W-1:0] row, input bit rdy, input bit clr);
        int   c, ai;
        bit   al, pp, ps;
        ent_t e;
        logic [W-1:0] cin;
        c = cyc;
        ring_v[c & 15] = v;
        ring_d[c & 15] = row;
        for (int j = 0; j < COLS; j++) cin[j*LW +: LW] = ring_d[(c - j) & 15][j*LW +: LW];
        C_in = cin; in_valid = v; m_ready = rdy; clear = clr;
        @(posedge clk);
        if (clr) begin
            model_flush();
        end else begin
            ai = (c - (COLS - 1)) & 15;
            al = ring_v[ai];
            pp = (mq.size() != 0) && rdy;
            ps = al && ((mq.size() < DEPTH) || pp);
            if (al && !ps) ovf = 1'b1;
            if (pp) void'(mq.pop_front());
            if (ps) begin
                e.d   = relu(ring_d[ai]);
                e.idx = 3'(rowcnt);
                mq.push_back(e);
            end
            if (al) rowcnt = (rowcnt + 1) % ROWS;
        end
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; m_ready = 1'b0;
        #1;
        chk("rst_m_valid", W'(m_valid), '0);
        chk("rst_m_data", m_data, '0);
        chk("rst_m_row_idx", W'(m_row_idx), '0);
        chk("rst_m_last", W'(m_last), '0);
        chk("rst_overflow", W'(overflow), '0);
        chk("rst_fifo_count", W'(fifo_count), '0);
        model_flush();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #2 rst_n = 1'b1;
    endtask

    logic [W-1:0] row, exp_row;

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        C_in = '0; in_valid = 1'b0; m_ready = 1'b0; clear = 1'b0;
        for (int k = 0; k < 16; k++) ring_d[k] = rand_row();
        do_reset();

        // Skew alignment: lane j = 0x0100+j
        for (int j = 0; j < COLS; j++) row[j*LW +: LW] = 16'h0100 + 16'(j);
        exp_row = row;
        tick(1, row, 0, 0);
        repeat (6) tick(0, rand_row(), 0, 0);
        chk("skew_early_valid", W'(m_valid), '0);
        tick(0, rand_row(), 0, 0);
        chk("skew_valid", W'(m_valid), W'(1));
        chk("skew_data", m_data, exp_row);
        chk("skew_row_idx", W'(m_row_idx), '0);
        repeat (3) tick(0, rand_row(), 1, 0);

        // Tile framing: 9 rows back to back
        tick(0, rand_row(), 1, 1);
        repeat (9) tick(1, rand_row(), 1, 0);
        repeat (10) tick(0, rand_row(), 1, 0);

        // Backpressure and overflow: 17 rows into a 16-entry FIFO
        tick(0, rand_row(), 0, 1);
        repeat (17) tick(1, rand_row(), 0, 0);
        repeat (7) tick(0, rand_row(), 0, 0);
        chk("ovf_count", W'(fifo_count), W'(16));
        chk("ovf_flag", W'(overflow), W'(1));
        repeat (16) tick(0, rand_row(), 1, 0);
        tick(1, rand_row(), 0, 0);
        repeat (7) tick(0, rand_row(), 0, 0);
        chk("ovf_next_idx", W'(m_row_idx), W'(1));
        repeat (2) tick(0, rand_row(), 1, 0);

        // Full FIFO with a pop in the aligning cycle
        tick(0, rand_row(), 0, 1);
        repeat (16) tick(1, rand_row(), 0, 0);
        repeat (7) tick(0, rand_row(), 0, 0);
        tick(1, rand_row(), 0, 0);
        repeat (6) tick(0, rand_row(), 0, 0);
        tick(0, rand_row(), 1, 0);
        chk("fullpop_count", W'(fifo_count), W'(16));
        chk("fullpop_ovf", W'(overflow), '0);
        repeat (20) tick(0, rand_row(), 1, 0);

        // Clear with 5 rows buffered and 3 in flight
        repeat (5) tick(1, rand_row(), 0, 0);
        repeat (7) tick(0, rand_row(), 0, 0);
        repeat (3) tick(1, rand_row(), 0, 0);
        tick(0, rand_row(), 0, 1);
        chk("clear_count", W'(fifo_count), '0);
        chk("clear_valid", W'(m_valid), '0);
        repeat (12) tick(0, rand_row(), 1, 0);

        // Sign handling: negative and positive lanes
        for (int j = 0; j < COLS; j++) row[j*LW +: LW] = (j % 2 == 0) ? 16'hFFF0 : 16'h007F;
`ifdef DESKEW_RELU_EN
        for (int j = 0; j < COLS; j++) exp_row[j*LW +: LW] = (j % 2 == 0) ? 16'h0000 : 16'h007F;
`else
        exp_row = row;
`endif
        tick(1, row, 0, 0);
        repeat (7) tick(0, rand_row(), 0, 0);
        chk("sign_data", m_data, exp_row);
        repeat (2) tick(0, rand_row(), 1, 0);

        // Reset in the middle of traffic
        repeat (10) tick(1, rand_row(), ($urandom_range(0, 1) == 1), 0);
        do_reset();

        // Random traffic with occasional clears
        for (int i = 0; i < 800; i++)
            tick(($urandom_range(0, 9) < 7), rand_row(), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) == 0));
        repeat (30) tick(0, rand_row(), 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
